// File: rtl/control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_pkg
// Description : Shared opcodes, IR field positions, FSM state encoding and
//               instruction-class decode for the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package control_unit_pkg;

  // IR field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // Register file geometry
  localparam int NREGS = 16;
  localparam int REGW  = 4;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_LD       = 5'b00000;
  localparam opcode_t OP_LDI      = 5'b00001;
  localparam opcode_t OP_ST       = 5'b00010;
  localparam opcode_t OP_ADD      = 5'b00011;
  localparam opcode_t OP_ALU_LAST = 5'b01011;
  localparam opcode_t OP_ADDI     = 5'b01100;
  localparam opcode_t OP_ORI      = 5'b01110;
  localparam opcode_t OP_MUL      = 5'b01111;
  localparam opcode_t OP_DIV      = 5'b10000;
  localparam opcode_t OP_MFHI     = 5'b11000;
  localparam opcode_t OP_MFLO     = 5'b11001;
  localparam opcode_t OP_NOP      = 5'b11010;
  localparam opcode_t OP_HALT     = 5'b11011;

  // FSM state encoding
  localparam logic [3:0] ST_FETCH0 = 4'd0;
  localparam logic [3:0] ST_FETCH1 = 4'd1;
  localparam logic [3:0] ST_FETCH2 = 4'd2;
  localparam logic [3:0] ST_EXEC3  = 4'd3;
  localparam logic [3:0] ST_EXEC4  = 4'd4;
  localparam logic [3:0] ST_EXEC5  = 4'd5;
  localparam logic [3:0] ST_EXEC6  = 4'd6;
  localparam logic [3:0] ST_EXEC7  = 4'd7;
  localparam logic [3:0] ST_HALT   = 4'd8;

  // Instruction classes sharing one execute sequence
  typedef enum logic [3:0] {
    CLS_NONE,    // nop and every undefined opcode
    CLS_ALU3,    // three-register ALU ops
    CLS_IMM,     // addi/andi/ori/ldi
    CLS_MULDIV,
    CLS_MFHI,
    CLS_MFLO,
    CLS_LD,
    CLS_ST,
    CLS_HALT
  } op_class_e;

  function automatic op_class_e decode_class(input opcode_t op);
    op_class_e cls;
    cls = CLS_NONE;
    if (op >= OP_ADD && op <= OP_ALU_LAST)                 cls = CLS_ALU3;
    else if ((op >= OP_ADDI && op <= OP_ORI) || op == OP_LDI) cls = CLS_IMM;
    else if (op == OP_MUL || op == OP_DIV)                 cls = CLS_MULDIV;
    else if (op == OP_MFHI)                                cls = CLS_MFHI;
    else if (op == OP_MFLO)                                cls = CLS_MFLO;
    else if (op == OP_LD)                                  cls = CLS_LD;
    else if (op == OP_ST)                                  cls = CLS_ST;
    else if (op == OP_HALT)                                cls = CLS_HALT;
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_if
// Description : Instruction/handshake inputs and datapath strobes between the
//               control unit (master) and the datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_if #(
  parameter int OPW = 5
);
  logic [31:0]    IR;
  logic           mem_done;
  logic           stop;
  logic [15:0]    Rin;
  logic [15:0]    Rout;
  logic           PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Cout;
  logic           ZLOout, ZHIout, HIin, Loin, HIout, Loout;
  logic           Read, Write;
  logic [OPW-1:0] ALU_opcode;
  logic           run;

  modport master (
    input  IR, mem_done, stop,
    output Rin, Rout,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Cout,
    output ZLOout, ZHIout, HIin, Loin, HIout, Loout,
    output Read, Write, ALU_opcode, run
  );

  modport slave (
    output IR, mem_done, stop,
    input  Rin, Rout,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Cout,
    input  ZLOout, ZHIout, HIin, Loin, HIout, Loout,
    input  Read, Write, ALU_opcode, run
  );
endinterface
`default_nettype wire

// File: rtl/control_unit_reg_select.sv
`default_nettype none
// ============================================================================
// Module      : reg_select
// Description : Decodes Ra/Rb/Rc plus enables into one-hot register-file
//               load (rin) and drive (rout) strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_select
  import control_unit_pkg::*;
(
  input  logic [REGW-1:0]  ra,
  input  logic [REGW-1:0]  rb,
  input  logic [REGW-1:0]  rc,
  input  logic             rin_en,
  input  logic             ra_out,
  input  logic             rb_out,
  input  logic             rc_out,
  output logic [NREGS-1:0] rin,
  output logic [NREGS-1:0] rout
);
  logic [REGW-1:0] out_idx;
  logic            out_en;

  // Pick the single field that drives the bus; at most one source at a time
  always_comb begin
    out_idx = rc;
    out_en  = 1'b1;
    if (ra_out)      out_idx = ra;
    else if (rb_out) out_idx = rb;
    else if (rc_out) out_idx = rc;
    else             out_en  = 1'b0;
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_onehot
    assign rin[i]  = rin_en && (ra == REGW'(i));
    assign rout[i] = out_en && (out_idx == REGW'(i));
  end
endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle fetch/execute sequencer producing Moore datapath
//               strobes from the current state and the instruction register.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
  import control_unit_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           clr,
  control_unit_if.master bus
);
  logic [3:0]      state_q, state_d;
  logic            fresh_q, fresh_d;
  opcode_t         opc;
  op_class_e       cls;
  logic [REGW-1:0] ra, rb, rc;
  logic            ir_unused;
  logic            rin_en, ra_out, rb_out, rc_out;
  opcode_t         alu_op;

  assign opc = bus.IR[OPC_MSB:OPC_LSB];
  assign ra  = bus.IR[RA_MSB:RA_LSB];
  assign rb  = bus.IR[RB_MSB:RB_LSB];
  assign rc  = bus.IR[RC_MSB:RC_LSB];
  assign cls = decode_class(opc);
  // Low IR bits carry immediates consumed by the datapath, not by control
  assign ir_unused = ^bus.IR[RC_LSB-1:0];

  // Next-state sequencing; memory waits stay put until mem_done
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH0: state_d = ST_FETCH1;
      ST_FETCH1: if (bus.mem_done) state_d = ST_FETCH2;
      ST_FETCH2: state_d = bus.stop ? ST_HALT : ST_EXEC3;
      ST_EXEC3: begin
        case (cls)
          CLS_NONE, CLS_MFHI, CLS_MFLO: state_d = ST_FETCH0;
          CLS_HALT:                     state_d = ST_HALT;
          default:                      state_d = ST_EXEC4;
        endcase
      end
      ST_EXEC4: state_d = ST_EXEC5;
      ST_EXEC5: state_d = (cls == CLS_ALU3 || cls == CLS_IMM) ? ST_FETCH0 : ST_EXEC6;
      ST_EXEC6: begin
        case (cls)
          CLS_LD:  if (bus.mem_done) state_d = ST_EXEC7;
          CLS_ST:  state_d = ST_EXEC7;
          default: state_d = ST_FETCH0;
        endcase
      end
      ST_EXEC7: if (cls != CLS_ST || bus.mem_done) state_d = ST_FETCH0;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH0;
    endcase
    // Marks the first cycle of a state so PCin fires once per fetch wait
    fresh_d = (state_d != state_q);
  end

  // State register; reset parks the sequencer at the start of a fetch
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_FETCH0;
      fresh_q <= 1'b1;
    end else begin
      state_q <= state_d;
      fresh_q <= fresh_d;
    end
  end

  // Moore strobe decode; everything is forced low while clr is held
  always_comb begin
    bus.PCout  = 1'b0; bus.PCin   = 1'b0; bus.IncPC  = 1'b0; bus.MARin = 1'b0;
    bus.MDRin  = 1'b0; bus.MDRout = 1'b0; bus.IRin   = 1'b0; bus.Yin   = 1'b0;
    bus.Zin    = 1'b0; bus.Cout   = 1'b0; bus.ZLOout = 1'b0; bus.ZHIout = 1'b0;
    bus.HIin   = 1'b0; bus.Loin   = 1'b0; bus.HIout  = 1'b0; bus.Loout = 1'b0;
    bus.Read   = 1'b0; bus.Write  = 1'b0;
    rin_en = 1'b0; ra_out = 1'b0; rb_out = 1'b0; rc_out = 1'b0;
    alu_op = '0;
    if (clr) begin
      case (state_q)
        ST_FETCH0: begin
          bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
        end
        ST_FETCH1: begin
          bus.ZLOout = 1'b1; bus.PCin = fresh_q; bus.Read = 1'b1; bus.MDRin = 1'b1;
        end
        ST_FETCH2: begin
          bus.MDRout = 1'b1; bus.IRin = 1'b1;
        end
        ST_EXEC3: begin
          case (cls)
            CLS_ALU3, CLS_IMM, CLS_LD, CLS_ST: begin rb_out = 1'b1; bus.Yin = 1'b1; end
            CLS_MULDIV: begin ra_out = 1'b1; bus.Yin = 1'b1; end
            CLS_MFHI:   begin bus.HIout = 1'b1; rin_en = 1'b1; end
            CLS_MFLO:   begin bus.Loout = 1'b1; rin_en = 1'b1; end
            default: ;
          endcase
        end
        ST_EXEC4: begin
          case (cls)
            CLS_ALU3:   begin rc_out = 1'b1; bus.Zin = 1'b1; alu_op = opc; end
            CLS_IMM:    begin bus.Cout = 1'b1; bus.Zin = 1'b1;
                              alu_op = (opc == OP_LDI) ? OP_ADD : opc; end
            CLS_LD, CLS_ST: begin bus.Cout = 1'b1; bus.Zin = 1'b1; alu_op = OP_ADD; end
            CLS_MULDIV: begin rb_out = 1'b1; bus.Zin = 1'b1; alu_op = opc; end
            default: ;
          endcase
        end
        ST_EXEC5: begin
          case (cls)
            CLS_ALU3, CLS_IMM: begin bus.ZLOout = 1'b1; rin_en = 1'b1; end
            CLS_LD, CLS_ST:    begin bus.ZLOout = 1'b1; bus.MARin = 1'b1; end
            CLS_MULDIV:        begin bus.ZLOout = 1'b1; bus.Loin = 1'b1; end
            default: ;
          endcase
        end
        ST_EXEC6: begin
          case (cls)
            CLS_MULDIV: begin bus.ZHIout = 1'b1; bus.HIin = 1'b1; end
            CLS_LD:     begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
            CLS_ST:     begin ra_out = 1'b1; bus.MDRin = 1'b1; end
            default: ;
          endcase
        end
        ST_EXEC7: begin
          case (cls)
            CLS_LD:  begin bus.MDRout = 1'b1; rin_en = 1'b1; end
            CLS_ST:  bus.Write = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Run indicator and ALU operation follow the same reset gating
  always_comb begin
    bus.run        = clr && (state_q != ST_HALT);
    bus.ALU_opcode = OPW'(alu_op);
  end

  reg_select u_reg_select (
    .ra     (ra),
    .rb     (rb),
    .rc     (rc),
    .rin_en (rin_en),
    .ra_out (ra_out),
    .rb_out (rb_out),
    .rc_out (rc_out),
    .rin    (bus.Rin),
    .rout   (bus.Rout)
  );
endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Directed self-checking bench for control_unit; each scenario
//               walks an instruction cycle by cycle against expected strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;
  logic clk;
  logic clr;
  int   n_cmp = 0;
  int   n_bad = 0;

  control_unit_if #(.OPW(5)) bus ();
  control_unit #(.OPW(5)) dut (.clk(clk), .clr(clr), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [17:0] B_PCOUT  = 18'h20000, B_PCIN   = 18'h10000, B_INCPC  = 18'h08000;
  localparam logic [17:0] B_MARIN  = 18'h04000, B_MDRIN  = 18'h02000, B_MDROUT = 18'h01000;
  localparam logic [17:0] B_IRIN   = 18'h00800, B_YIN    = 18'h00400, B_ZIN    = 18'h00200;
  localparam logic [17:0] B_COUT   = 18'h00100, B_ZLOOUT = 18'h00080, B_ZHIOUT = 18'h00040;
  localparam logic [17:0] B_HIIN   = 18'h00020, B_LOIN   = 18'h00010, B_HIOUT  = 18'h00008;
  localparam logic [17:0] B_LOOUT  = 18'h00004, B_READ   = 18'h00002, B_WRITE  = 18'h00001;
  localparam logic [17:0] F0  = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [17:0] F1E = B_ZLOOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [17:0] F1  = B_ZLOOUT | B_READ | B_MDRIN;
  localparam logic [17:0] F2  = B_MDROUT | B_IRIN;

  typedef struct {
    logic [17:0] s;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  op;
    logic        run;
    logic        md;
    logic        st;
  } step_t;

  function automatic step_t mk(input logic [17:0] s, input logic [15:0] rin,
                               input logic [15:0] rout, input logic [4:0] op,
                               input logic run, input logic md, input logic st);
    step_t t;
    t.s = s; t.rin = rin; t.rout = rout; t.op = op; t.run = run; t.md = md; t.st = st;
    return t;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  function automatic logic [17:0] obs();
    return {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin,
            bus.Yin, bus.Zin, bus.Cout, bus.ZLOout, bus.ZHIout, bus.HIin, bus.Loin,
            bus.HIout, bus.Loout, bus.Read, bus.Write};
  endfunction

  task automatic do_reset();
    clr = 1'b0;
    bus.mem_done = 1'b0;
    bus.stop = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    bus.IR = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
    bus.mem_done = 1'b1;
    bus.stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({obs(), bus.Rin, bus.Rout, bus.ALU_opcode} !== {18'h0, 16'h0, 16'h0, 5'h0}) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: got strb=%h rin=%h rout=%h op=%b, want all zero",
                 c, obs(), bus.Rin, bus.Rout, bus.ALU_opcode);
      end
    end
    clr = 1'b1; #1;
    n_cmp++;
    if ({obs(), bus.run} !== {F0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_release: got strb=%h run=%b, want strb=%h run=1", obs(), bus.run, F0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (obs() !== F1E) begin
      n_bad++;
      $display("FAIL reset_fetch1: got strb=%h, want %h", obs(), F1E);
    end
  endtask

  task automatic test_sub();
    step_t v[$];
    bus.IR = 32'h20228000;
    v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F1E, 16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F2,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(B_YIN, 16'h0, 16'h0010, 5'd0, 1, 1, 0));
    v.push_back(mk(B_ZIN, 16'h0, 16'h0020, 5'b00100, 1, 1, 0));
    v.push_back(mk(B_ZLOOUT, 16'h0001, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    do_reset();
    foreach (v[i]) begin
      bus.mem_done = v[i].md; bus.stop = v[i].st; #1;
      n_cmp++;
      if ({obs(), bus.Rin, bus.Rout, bus.run, bus.ALU_opcode} !==
          {v[i].s, v[i].rin, v[i].rout, v[i].run, v[i].op}) begin
        n_bad++;
        $display("FAIL sub cyc%0d: got strb=%h rin=%h rout=%h run=%b op=%b, want strb=%h rin=%h rout=%h run=%b op=%b",
                 i, obs(), bus.Rin, bus.Rout, bus.run, bus.ALU_opcode,
                 v[i].s, v[i].rin, v[i].rout, v[i].run, v[i].op);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ld_wait();
    step_t v[$];
    bus.IR = mk_ir(5'b00000, 4'd1, 4'd2, 4'd0);
    v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(F1E, 16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(F1,  16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(F1,  16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(F1,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F2,  16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(B_YIN, 16'h0, 16'h0004, 5'd0, 1, 0, 0));
    v.push_back(mk(B_COUT | B_ZIN, 16'h0, 16'h0, 5'b00011, 1, 0, 0));
    v.push_back(mk(B_ZLOOUT | B_MARIN, 16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(B_READ | B_MDRIN, 16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(B_READ | B_MDRIN, 16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(B_READ | B_MDRIN, 16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(B_READ | B_MDRIN, 16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(B_MDROUT, 16'h0002, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 0, 0));
    do_reset();
    foreach (v[i]) begin
      bus.mem_done = v[i].md; bus.stop = v[i].st; #1;
      n_cmp++;
      if ({obs(), bus.Rin, bus.Rout, bus.run, bus.ALU_opcode} !==
          {v[i].s, v[i].rin, v[i].rout, v[i].run, v[i].op}) begin
        n_bad++;
        $display("FAIL ld_wait cyc%0d: got strb=%h rin=%h rout=%h run=%b op=%b, want strb=%h rin=%h rout=%h run=%b op=%b",
                 i, obs(), bus.Rin, bus.Rout, bus.run, bus.ALU_opcode,
                 v[i].s, v[i].rin, v[i].rout, v[i].run, v[i].op);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    step_t v[$];
    bus.IR = mk_ir(5'b01111, 4'd3, 4'd4, 4'd0);
    v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F1E, 16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F2,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(B_YIN, 16'h0, 16'h0008, 5'd0, 1, 1, 0));
    v.push_back(mk(B_ZIN, 16'h0, 16'h0010, 5'd0, 1, 1, 0));
    v.push_back(mk(B_ZLOOUT | B_LOIN, 16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(B_ZHIOUT | B_HIIN, 16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    do_reset();
    foreach (v[i]) begin
      bus.mem_done = v[i].md; bus.stop = v[i].st; #1;
      n_cmp++;
      if ({obs(), bus.Rin, bus.Rout, bus.run} !== {v[i].s, v[i].rin, v[i].rout, v[i].run}) begin
        n_bad++;
        $display("FAIL mul cyc%0d: got strb=%h rin=%h rout=%h run=%b, want strb=%h rin=%h rout=%h run=%b",
                 i, obs(), bus.Rin, bus.Rout, bus.run, v[i].s, v[i].rin, v[i].rout, v[i].run);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_st_reset();
    step_t v[$];
    bus.IR = mk_ir(5'b00010, 4'd6, 4'd7, 4'd0);
    v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F1E, 16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F2,  16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(B_YIN, 16'h0, 16'h0080, 5'd0, 1, 0, 0));
    v.push_back(mk(B_COUT | B_ZIN, 16'h0, 16'h0, 5'b00011, 1, 0, 0));
    v.push_back(mk(B_ZLOOUT | B_MARIN, 16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(B_MDRIN, 16'h0, 16'h0040, 5'd0, 1, 0, 0));
    v.push_back(mk(B_WRITE, 16'h0, 16'h0, 5'd0, 1, 0, 0));
    v.push_back(mk(B_WRITE, 16'h0, 16'h0, 5'd0, 1, 0, 0));
    do_reset();
    foreach (v[i]) begin
      bus.mem_done = v[i].md; bus.stop = v[i].st; #1;
      n_cmp++;
      if ({obs(), bus.Rin, bus.Rout, bus.run, bus.ALU_opcode} !==
          {v[i].s, v[i].rin, v[i].rout, v[i].run, v[i].op}) begin
        n_bad++;
        $display("FAIL st cyc%0d: got strb=%h rin=%h rout=%h run=%b op=%b, want strb=%h rin=%h rout=%h run=%b op=%b",
                 i, obs(), bus.Rin, bus.Rout, bus.run, bus.ALU_opcode,
                 v[i].s, v[i].rin, v[i].rout, v[i].run, v[i].op);
      end
      @(posedge clk); #1;
    end
    // Still waiting in EXEC7: drop clr between edges
    clr = 1'b0; #1;
    n_cmp++;
    if ({obs(), bus.Rin, bus.Rout} !== {18'h0, 16'h0, 16'h0}) begin
      n_bad++;
      $display("FAIL st_mid_reset: got strb=%h rin=%h rout=%h, want all zero", obs(), bus.Rin, bus.Rout);
    end
    @(posedge clk); #1;
    clr = 1'b1; bus.mem_done = 1'b1; #1;
    n_cmp++;
    if ({obs(), bus.run} !== {F0, 1'b1}) begin
      n_bad++;
      $display("FAIL st_release: got strb=%h run=%b, want strb=%h run=1", obs(), bus.run, F0);
    end
  endtask

  task automatic test_stop();
    step_t v[$];
    bus.IR = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
    v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F1E, 16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F2,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(B_YIN, 16'h0, 16'h0004, 5'd0, 1, 1, 0));
    v.push_back(mk(B_ZIN, 16'h0, 16'h0008, 5'b00011, 1, 1, 1));
    v.push_back(mk(B_ZLOOUT, 16'h0002, 16'h0, 5'd0, 1, 1, 1));
    v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 1));
    v.push_back(mk(F1E, 16'h0, 16'h0, 5'd0, 1, 1, 1));
    v.push_back(mk(F2,  16'h0, 16'h0, 5'd0, 1, 1, 1));
    v.push_back(mk(18'h0, 16'h0, 16'h0, 5'd0, 0, 1, 1));
    v.push_back(mk(18'h0, 16'h0, 16'h0, 5'd0, 0, 1, 0));
    v.push_back(mk(18'h0, 16'h0, 16'h0, 5'd0, 0, 1, 0));
    do_reset();
    foreach (v[i]) begin
      bus.mem_done = v[i].md; bus.stop = v[i].st; #1;
      n_cmp++;
      if ({obs(), bus.Rin, bus.Rout, bus.run, bus.ALU_opcode} !==
          {v[i].s, v[i].rin, v[i].rout, v[i].run, v[i].op}) begin
        n_bad++;
        $display("FAIL stop cyc%0d: got strb=%h rin=%h rout=%h run=%b op=%b, want strb=%h rin=%h rout=%h run=%b op=%b",
                 i, obs(), bus.Rin, bus.Rout, bus.run, bus.ALU_opcode,
                 v[i].s, v[i].rin, v[i].rout, v[i].run, v[i].op);
      end
      @(posedge clk); #1;
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_undefined();
    step_t v[$];
    bus.IR = mk_ir(5'b11111, 4'd5, 4'd6, 4'd7);
    v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F1E, 16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F2,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(18'h0, 16'h0, 16'h0, 5'd0, 1, 1, 0));
    v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 0));
    do_reset();
    foreach (v[i]) begin
      bus.mem_done = v[i].md; bus.stop = v[i].st; #1;
      n_cmp++;
      if ({obs(), bus.Rin, bus.Rout, bus.run, bus.ALU_opcode} !==
          {v[i].s, v[i].rin, v[i].rout, v[i].run, v[i].op}) begin
        n_bad++;
        $display("FAIL undef cyc%0d: got strb=%h rin=%h rout=%h run=%b op=%b, want strb=%h rin=%h rout=%h run=%b op=%b",
                 i, obs(), bus.Rin, bus.Rout, bus.run, bus.ALU_opcode,
                 v[i].s, v[i].rin, v[i].rout, v[i].run, v[i].op);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    step_t v[$];
    // halt opcode reached through EXEC3, then halt opcode with stop at FETCH2
    for (int pass = 0; pass < 2; pass++) begin
      v.delete();
      bus.IR = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
      v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 0));
      v.push_back(mk(F1E, 16'h0, 16'h0, 5'd0, 1, 1, 0));
      v.push_back(mk(F2,  16'h0, 16'h0, 5'd0, 1, 1, pass[0]));
      if (pass == 0) v.push_back(mk(18'h0, 16'h0, 16'h0, 5'd0, 1, 1, 0));
      v.push_back(mk(18'h0, 16'h0, 16'h0, 5'd0, 0, 1, pass[0]));
      v.push_back(mk(18'h0, 16'h0, 16'h0, 5'd0, 0, 1, 0));
      v.push_back(mk(18'h0, 16'h0, 16'h0, 5'd0, 0, 1, 0));
      do_reset();
      foreach (v[i]) begin
        bus.mem_done = v[i].md; bus.stop = v[i].st; #1;
        n_cmp++;
        if ({obs(), bus.Rin, bus.Rout, bus.run} !== {v[i].s, v[i].rin, v[i].rout, v[i].run}) begin
          n_bad++;
          $display("FAIL halt p%0d cyc%0d: got strb=%h rin=%h rout=%h run=%b, want strb=%h rin=%h rout=%h run=%b",
                   pass, i, obs(), bus.Rin, bus.Rout, bus.run, v[i].s, v[i].rin, v[i].rout, v[i].run);
        end
        @(posedge clk); #1;
      end
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_mfhi_mflo();
    step_t v[$];
    for (int pass = 0; pass < 2; pass++) begin
      v.delete();
      bus.IR = mk_ir(pass == 0 ? 5'b11000 : 5'b11001, 4'd9, 4'd2, 4'd3);
      v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 0));
      v.push_back(mk(F1E, 16'h0, 16'h0, 5'd0, 1, 1, 0));
      v.push_back(mk(F2,  16'h0, 16'h0, 5'd0, 1, 1, 0));
      v.push_back(mk(pass == 0 ? B_HIOUT : B_LOOUT, 16'h0200, 16'h0, 5'd0, 1, 1, 0));
      v.push_back(mk(F0,  16'h0, 16'h0, 5'd0, 1, 1, 0));
      do_reset();
      foreach (v[i]) begin
        bus.mem_done = v[i].md; bus.stop = v[i].st; #1;
        n_cmp++;
        if ({obs(), bus.Rin, bus.Rout, bus.run} !== {v[i].s, v[i].rin, v[i].rout, v[i].run}) begin
          n_bad++;
          $display("FAIL mfhilo p%0d cyc%0d: got strb=%h rin=%h rout=%h run=%b, want strb=%h rin=%h rout=%h run=%b",
                   pass, i, obs(), bus.Rin, bus.Rout, bus.run, v[i].s, v[i].rin, v[i].rout, v[i].run);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    clr = 1'b0;
    bus.IR = '0;
    bus.mem_done = 1'b0;
    bus.stop = 1'b0;
    test_reset();
    test_sub();
    test_ld_wait();
    test_mul();
    test_st_reset();
    test_stop();
    test_undefined();
    test_halt();
    test_mfhi_mflo();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
